// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a per-register scoreboard (busy bits),
// optional same-cycle write bypass and optional hardwired-zero register 0.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RPORTS = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RPORTS-1:0]            rbusy,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic                             set_en,
  input  logic [ADDR_WIDTH-1:0]            set_addr,
  output logic [2**ADDR_WIDTH-1:0]         busy_vec
);

  localparam int DEPTH      = 2**ADDR_WIDTH;
  localparam bit HAS_BYPASS = (BYPASS != 0);
  localparam bit HAS_ZERO   = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy_next;
  logic                  write_ok;

  // Writes to a hardwired-zero register 0 are dropped so rf[0] stays 0.
  assign write_ok = wen && !(HAS_ZERO && (waddr == '0));

  // NOTE: the storage array is reset like any other state here because the
  // block must read back 0 from every register straight out of reset; this
  // keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) begin
        rf[k] <= '0;
      end
    end else if (write_ok) begin
      // NOTE: sequential state is only ever updated with non-blocking
      // assignments so every flop samples the pre-edge values.
      rf[waddr] <= wdata;
    end
  end

  // Scoreboard next state: clear on writeback first, then a same-cycle
  // issue to the same register re-sets it (the new producer wins).
  always_comb begin
    // NOTE: assigning the full default first means no path leaves a bit
    // unassigned, so no latch is inferred.
    busy_next = busy_vec;
    if (wen) begin
      busy_next[waddr] = 1'b0;
    end
    if (set_en) begin
      busy_next[set_addr] = 1'b1;
    end
    if (HAS_ZERO) begin
      busy_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    logic [ADDR_WIDTH-1:0] port_addr;
    logic [DATA_WIDTH-1:0] port_data;
    logic                  port_busy;

    assign port_addr = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Priority: zero register, then bypass from writeback, then storage.
    // Bypass is gated by resetn so outputs read 0 for the whole reset.
    always_comb begin
      port_data = rf[port_addr];
      port_busy = busy_vec[port_addr];
      if (HAS_BYPASS && resetn && wen && (waddr == port_addr)) begin
        port_data = wdata;
        port_busy = 1'b0;
      end
      if (HAS_ZERO && (port_addr == '0)) begin
        port_data = '0;
        port_busy = 1'b0;
      end
    end

    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = port_data;
    assign rbusy[p]                          = port_busy;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (bypass+zero-reg, and neither) share
// stimulus; a reference model queues expectations and a monitor checks them.
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NP    = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [NP*AW-1:0] raddr = '0;
  logic             wen = 1'b0;
  logic [AW-1:0]    waddr = '0;
  logic [DW-1:0]    wdata = '0;
  logic             set_en = 1'b0;
  logic [AW-1:0]    set_addr = '0;

  logic [NP*DW-1:0] rdata_a, rdata_b;
  logic [NP-1:0]    rbusy_a, rbusy_b;
  logic [DEPTH-1:0] busy_a, busy_b;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RPORTS(NP),
                .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata_a),
    .rbusy(rbusy_a), .wen(wen), .waddr(waddr), .wdata(wdata),
    .set_en(set_en), .set_addr(set_addr), .busy_vec(busy_a));

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RPORTS(NP),
                .BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata_b),
    .rbusy(rbusy_b), .wen(wen), .waddr(waddr), .wdata(wdata),
    .set_en(set_en), .set_addr(set_addr), .busy_vec(busy_b));

  typedef struct {
    string       name;
    logic [63:0] rd_a, rd_b;
    logic [1:0]  rb_a, rb_b;
    logic [31:0] bv_a, bv_b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: config 0 = bypass + zero reg, config 1 = plain.
  bit            byp [2] = '{1'b1, 1'b0};
  bit            zr  [2] = '{1'b1, 1'b0};
  logic [DW-1:0] m_rf   [2][DEPTH];
  bit            m_busy [2][DEPTH];
  bit            m_rst;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void clear_model();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_rf[c][k]   = '0;
        m_busy[c][k] = 1'b0;
      end
    end
  endfunction

  function automatic void ref_read(input int c, input logic [AW-1:0] a,
                                   output logic [DW-1:0] d, output logic b);
    if (m_rst || (zr[c] && a == 0)) begin
      d = '0; b = 1'b0;
    end else if (byp[c] && wen && waddr == a) begin
      d = wdata; b = 1'b0;
    end else begin
      d = m_rf[c][a]; b = m_busy[c][a];
    end
  endfunction

  function automatic exp_t expect_now(input string nm);
    exp_t          e;
    logic [63:0]   rd [2];
    logic [1:0]    rb [2];
    logic [31:0]   bv [2];
    logic [DW-1:0] d;
    logic          b;
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < NP; p++) begin
        ref_read(c, raddr[p*AW +: AW], d, b);
        rd[c][p*DW +: DW] = d;
        rb[c][p]          = b;
      end
      for (int k = 0; k < DEPTH; k++) bv[c][k] = m_busy[c][k];
    end
    e.name = nm;
    e.rd_a = rd[0]; e.rd_b = rd[1];
    e.rb_a = rb[0]; e.rb_b = rb[1];
    e.bv_a = bv[0]; e.bv_b = bv[1];
    return e;
  endfunction

  // Effect of the coming clock edge: store, then clear-on-write, then set wins.
  function automatic void commit();
    for (int c = 0; c < 2; c++) begin
      if (wen && !(zr[c] && waddr == 0)) m_rf[c][waddr] = wdata;
      if (wen) m_busy[c][waddr] = 1'b0;
      if (set_en && !(zr[c] && set_addr == 0)) m_busy[c][set_addr] = 1'b1;
    end
  endfunction

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic s, input logic [AW-1:0] sa,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1, input string nm);
    @(posedge clk); #1;
    wen = w; waddr = wa; wdata = wd;
    set_en = s; set_addr = sa;
    raddr = {r1, r0};
    exp_q.push_back(expect_now(nm));
    commit();
  endtask

  task automatic reset_mid(input logic [AW-1:0] r, input string nm);
    @(posedge clk); #1;
    wen = 1'b0; set_en = 1'b0; raddr = {r, r};
    #1;
    resetn = 1'b0;
    m_rst  = 1'b1;
    clear_model();
    exp_q.push_back(expect_now(nm));
    @(negedge clk); #1;
    resetn = 1'b1;
    m_rst  = 1'b0;
  endtask

  task automatic random_phase(input int n);
    logic [AW-1:0] a [4];
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        a[j] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7))
                                           : AW'($urandom_range(0, DEPTH - 1));
      end
      drive(($urandom_range(0, 1) == 1), a[0], $urandom(),
            ($urandom_range(0, 9) < 4), a[1], a[2], a[3], "random");
    end
  endtask

  // Monitor: compare queued expectations at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, "/rdata_a"}, 64'(rdata_a), e.rd_a);
        check({e.name, "/rbusy_a"}, 64'(rbusy_a), 64'(e.rb_a));
        check({e.name, "/busy_a"},  64'(busy_a),  64'(e.bv_a));
        check({e.name, "/rdata_b"}, 64'(rdata_b), e.rd_b);
        check({e.name, "/rbusy_b"}, 64'(rbusy_b), 64'(e.rb_b));
        check({e.name, "/busy_b"},  64'(busy_b),  64'(e.bv_b));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_rst = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;

    drive(0, 0, 0, 0, 0, 0, 1, "reset_state");
    // Reset clears stored data and busy bits mid-cycle.
    drive(1, 5, 32'h1234, 1, 5, 5, 5, "pre_reset_wr");
    drive(0, 0, 0, 0, 0, 5, 5, "pre_reset_rd");
    reset_mid(5, "reset_mid");
    drive(0, 0, 0, 0, 0, 5, 5, "post_reset_rd");
    // Write then read on both ports.
    drive(1, 3, 32'hDEADBEEF, 0, 0, 3, 3, "wr3");
    drive(0, 0, 0, 0, 0, 3, 3, "rd3");
    // Bypass versus pre-write contents.
    drive(1, 7, 32'h1, 0, 0, 0, 0, "wr7");
    drive(1, 7, 32'h55, 0, 0, 7, 7, "bypass7");
    drive(0, 0, 0, 0, 0, 7, 3, "rd7");
    // Register 0: hardwired zero versus ordinary.
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, "zero_wr");
    drive(0, 0, 0, 0, 0, 0, 0, "zero_rd");
    // Scoreboard lifecycle.
    drive(0, 0, 0, 1, 9, 9, 9, "set9");
    drive(0, 0, 0, 0, 0, 9, 9, "busy9");
    drive(1, 9, 32'h99, 0, 0, 9, 9, "wb9");
    drive(0, 0, 0, 0, 0, 9, 9, "free9");
    // Set/clear collision: set wins.
    drive(0, 0, 0, 1, 4, 4, 4, "set4");
    drive(1, 4, 32'h10, 1, 4, 4, 4, "collide4");
    drive(0, 0, 0, 0, 0, 4, 4, "after4");
    // Set and write to different registers in one cycle.
    drive(1, 6, 32'hABCD, 1, 8, 6, 8, "split68");
    drive(0, 0, 0, 0, 0, 6, 8, "rd68");

    random_phase(400);
    reset_mid(AW'($urandom_range(1, DEPTH - 1)), "reset_mid2");
    random_phase(300);
    drive(0, 0, 0, 0, 0, 0, 0, "idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
